// File: rtl/mem_issue_sequencer.sv
// rtl/mem_issue_sequencer.sv - issues a dual-issue memory group (lane1 then lane2) onto one dcache/AGU port
// Holds each request until mem_ok, kills lane2 on a lane1 exception and drains an in-flight access on flush.
module mem_issue_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REQ_W  = ADDR_W + DATA_W + 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [REQ_W-1:0]  in_bus1,
  input  logic [REQ_W-1:0]  in_bus2,
  output logic              mem_req_valid,
  output logic [REQ_W-1:0]  mem_req_bus,
  output logic              mem_req_lane,
  input  logic              mem_ok,
  input  logic              mem_excp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic              out_excp,
  output logic              out_kill2
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ1  = 3'd1;
  localparam logic [2:0] REQ2  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]        state, state_n;
  logic [REQ_W-1:0]  bus1_q, bus2_q;
  logic              use2_q;
  logic              lane_q;
  logic [DATA_W-1:0] data1_q, data2_q;
  logic              excp_q, kill2_q;
  logic              req_active;
  logic [REQ_W-1:0]  issue_bus;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          if (in_use1)      state_n = REQ1;
          else if (in_use2) state_n = REQ2;
          else              state_n = DONE;
        end
      end
      REQ1: begin
        if (mem_ok) begin
          if (flush)                 state_n = IDLE;
          else if (mem_excp)         state_n = DONE;
          else if (use2_q)           state_n = REQ2;
          else                       state_n = DONE;
        end else if (flush) begin
          state_n = DRAIN;
        end
      end
      REQ2: begin
        if (mem_ok)      state_n = flush ? IDLE : DONE;
        else if (flush)  state_n = DRAIN;
      end
      DONE:    state_n = IDLE;
      DRAIN:   if (mem_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bus1_q  <= '0;
      bus2_q  <= '0;
      use2_q  <= 1'b0;
      lane_q  <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      excp_q  <= 1'b0;
      kill2_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid && !flush) begin
        bus1_q <= in_bus1;
        bus2_q <= in_bus2;
        use2_q <= in_use2;
      end
      if (state == REQ1 && mem_ok && !flush) begin
        data1_q <= mem_rdata;
        if (mem_excp) begin
          excp_q  <= 1'b1;
          kill2_q <= use2_q;
        end
      end
      if (state == REQ2 && mem_ok && !flush) begin
        data2_q <= mem_rdata;
        excp_q  <= mem_excp;
      end
      // lane_q survives into DRAIN so the committed request stays on the bus unchanged
      if (state_n == REQ1)      lane_q <= 1'b0;
      else if (state_n == REQ2) lane_q <= 1'b1;
      if (state_n == IDLE && state != IDLE) begin
        data1_q <= '0;
        data2_q <= '0;
        excp_q  <= 1'b0;
        kill2_q <= 1'b0;
      end
    end
  end

  // cacop is a lane1-only operation, so its fields never leave on a lane2 issue
  assign issue_bus     = lane_q ? {4'b0000, bus2_q[REQ_W-5:0]} : bus1_q;
  assign req_active    = (state == REQ1) || (state == REQ2) || (state == DRAIN);
  assign mem_req_valid = req_active;
  assign mem_req_bus   = req_active ? issue_bus : '0;
  assign mem_req_lane  = req_active && lane_q;
  assign in_ready      = (state == IDLE);
  // DONE lasts one cycle, so a flush landing on it can only suppress the pulse directly
  assign out_valid     = (state == DONE) && !flush;
  assign out_data1     = data1_q;
  assign out_data2     = data2_q;
  assign out_excp      = excp_q;
  assign out_kill2     = kill2_q;

endmodule
